// File: rtl/musb_trace_buffer_pkg.sv
// State encodings and trace-entry layout shared by the MUSB trace buffer files.
package musb_trace_buffer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_POST  = 3'd2,
    ST_DONE  = 3'd3
  } trace_state_e;

  localparam int                DROP_W   = 16;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  // Channel id field is never narrower than one bit, even for a single channel.
  function automatic int ch_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  // Entry layout, LSB first: data, addr, channel id.
  localparam int ENT_DATA_LSB = 0;

  function automatic int ent_addr_lsb(input int dw);
    return dw;
  endfunction

  function automatic int ent_ch_lsb(input int dw);
    return 2 * dw;
  endfunction

  function automatic int entry_width(input int ch_w, input int dw);
    return ch_w + 2 * dw;
  endfunction

endpackage

// File: rtl/musb_trace_ram.sv
// Simple dual-port trace storage: one write port, registered read port.
module musb_trace_ram #(
  parameter int WIDTH      = 65,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/musb_trace_buffer.sv
// Multi-channel event trace buffer: circular capture, trigger with post-window,
// then valid/ready readout from the oldest entry.
module musb_trace_buffer
  import musb_trace_buffer_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int N_CH       = 2,
  parameter  int DEPTH_LOG2 = 6,
  parameter  int POST_TRIG  = 16,
  localparam int CH_W       = ch_width(N_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       arm,
  input  logic                       enable,
  input  logic [N_CH-1:0]            ch_valid,
  input  logic [N_CH*DATA_WIDTH-1:0] ch_addr,
  input  logic [N_CH*DATA_WIDTH-1:0] ch_data,
  input  logic                       trigger,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [CH_W-1:0]            rd_ch,
  output logic [DATA_WIDTH-1:0]      rd_addr,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic [2:0]                 state,
  output logic [DEPTH_LOG2:0]        count,
  output logic [DROP_W-1:0]          dropped,
  output logic                       done
);

  localparam int ENT_W    = entry_width(CH_W, DATA_WIDTH);
  localparam int ADDR_LSB = ent_addr_lsb(DATA_WIDTH);
  localparam int CH_LSB   = ent_ch_lsb(DATA_WIDTH);

  localparam logic [DEPTH_LOG2:0]   CNT_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] POST_LOAD = DEPTH_LOG2'(POST_TRIG);

  trace_state_e          st;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] post_cnt;

  logic [CH_W-1:0]       win_ch;
  logic [DATA_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;
  logic [16:0]           n_valid;
  logic [16:0]           drop_sum;
  logic [DROP_W-1:0]     drop_next;
  logic                  cap_en;

  logic [ENT_W-1:0]      wdata;
  logic [ENT_W-1:0]      rdata;

  // Lowest-index valid channel wins; the rest are counted as dropped.
  always_comb begin
    win_ch   = '0;
    win_addr = '0;
    win_data = '0;
    n_valid  = '0;
    for (int i = N_CH-1; i >= 0; i--) begin
      if (ch_valid[i]) begin
        win_ch   = CH_W'(i);
        win_addr = ch_addr[i*DATA_WIDTH +: DATA_WIDTH];
        win_data = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
        n_valid  = n_valid + 17'd1;
      end
    end
  end

  assign cap_en    = (st == ST_ARMED || st == ST_POST) && enable && (|ch_valid) && !arm;
  assign drop_sum  = 17'(dropped) + n_valid - 17'd1;
  assign drop_next = drop_sum[16] ? DROP_MAX : drop_sum[DROP_W-1:0];
  assign wdata     = {win_ch, win_addr, win_data};

  // The oldest held entry always sits count slots behind the write pointer,
  // so the read pointer advances implicitly as count drops on each accept.
  assign rd_ptr = wr_ptr - count[DEPTH_LOG2-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_IDLE;
      wr_ptr   <= '0;
      post_cnt <= '0;
      count    <= '0;
      dropped  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
    end else if (arm) begin
      st       <= ST_ARMED;
      wr_ptr   <= '0;
      post_cnt <= '0;
      count    <= '0;
      dropped  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (cap_en) begin
        wr_ptr  <= wr_ptr + PTR_ONE;
        dropped <= drop_next;
        if (count != CNT_FULL) count <= count + (DEPTH_LOG2+1)'(1);
      end
      case (st)
        ST_ARMED: begin
          if (trigger) begin
            if (POST_TRIG == 0) begin
              st   <= ST_DONE;
              done <= 1'b1;
            end else begin
              st       <= ST_POST;
              post_cnt <= POST_LOAD;
            end
          end
        end
        ST_POST: begin
          if (cap_en) begin
            post_cnt <= post_cnt - PTR_ONE;
            if (post_cnt == PTR_ONE) begin
              st   <= ST_DONE;
              done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          // One idle cycle between words gives the RAM read its latency.
          if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
            count    <= count - (DEPTH_LOG2+1)'(1);
          end else if (!rd_valid && count != '0) begin
            rd_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign state = st;

  musb_trace_ram #(
    .WIDTH      (ENT_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (clk),
    .we    (cap_en),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  assign rd_data = rdata[ENT_DATA_LSB +: DATA_WIDTH];
  assign rd_addr = rdata[ADDR_LSB +: DATA_WIDTH];
  assign rd_ch   = rdata[CH_LSB +: CH_W];

endmodule

// File: tb/tb_musb_trace_buffer.sv
// Bench for musb_trace_buffer: two instances (POST_TRIG=2 and POST_TRIG=0) share
// stimulus and are checked against a queue-based reference model.
module tb_musb_trace_buffer;

  localparam int DW = 32, NCH = 2, DL = 6, DEPTH = 64;

  logic clk = 1'b0;
  logic rst, arm, enable, trigger, rd_ready;
  logic [NCH-1:0]    ch_valid;
  logic [NCH*DW-1:0] ch_addr, ch_data;

  logic          rdv  [2];
  logic [0:0]    rch  [2];
  logic [DW-1:0] raddr[2];
  logic [DW-1:0] rdata[2];
  logic [2:0]    st   [2];
  logic [DL:0]   cnt  [2];
  logic [15:0]   drp  [2];
  logic          dn   [2];

  always #5 clk = ~clk;

  musb_trace_buffer #(.DATA_WIDTH(DW), .N_CH(NCH), .DEPTH_LOG2(DL), .POST_TRIG(2)) u_pt2 (
    .clk(clk), .rst(rst), .arm(arm), .enable(enable), .ch_valid(ch_valid),
    .ch_addr(ch_addr), .ch_data(ch_data), .trigger(trigger), .rd_ready(rd_ready),
    .rd_valid(rdv[0]), .rd_ch(rch[0]), .rd_addr(raddr[0]), .rd_data(rdata[0]),
    .state(st[0]), .count(cnt[0]), .dropped(drp[0]), .done(dn[0]));

  musb_trace_buffer #(.DATA_WIDTH(DW), .N_CH(NCH), .DEPTH_LOG2(DL), .POST_TRIG(0)) u_pt0 (
    .clk(clk), .rst(rst), .arm(arm), .enable(enable), .ch_valid(ch_valid),
    .ch_addr(ch_addr), .ch_data(ch_data), .trigger(trigger), .rd_ready(rd_ready),
    .rd_valid(rdv[1]), .rd_ch(rch[1]), .rd_addr(raddr[1]), .rd_data(rdata[1]),
    .state(st[1]), .count(cnt[1]), .dropped(drp[1]), .done(dn[1]));

  // Reference model: the queue holds exactly the entries still owed to the reader.
  typedef struct { int ch; logic [DW-1:0] a; logic [DW-1:0] d; } ent_t;
  ent_t mq[2][$];
  int   mst[2], mpost[2], mdrop[2];
  bit   mrdv[2];
  int   passed = 0, total = 0;

  task automatic model_update();
    int pt, ost, nv, w;
    bit cap;
    ent_t e;
    for (int d = 0; d < 2; d++) begin
      pt  = (d == 0) ? 2 : 0;
      ost = mst[d];
      if (rst || arm) begin
        mst[d] = rst ? 0 : 1;
        mq[d].delete();
        mpost[d] = 0; mdrop[d] = 0; mrdv[d] = 0;
      end else begin
        cap = (ost == 1 || ost == 2) && enable && (ch_valid != '0);
        if (cap) begin
          nv = 0; w = 0;
          for (int c = NCH-1; c >= 0; c--) if (ch_valid[c]) begin nv++; w = c; end
          e.ch = w; e.a = ch_addr[w*DW +: DW]; e.d = ch_data[w*DW +: DW];
          mq[d].push_back(e);
          if (mq[d].size() > DEPTH) void'(mq[d].pop_front());
          mdrop[d] = mdrop[d] + nv - 1;
          if (mdrop[d] > 65535) mdrop[d] = 65535;
        end
        if (ost == 1 && trigger) begin
          if (pt == 0) mst[d] = 3;
          else begin mst[d] = 2; mpost[d] = pt; end
        end else if (ost == 2 && cap) begin
          mpost[d]--;
          if (mpost[d] == 0) mst[d] = 3;
        end else if (ost == 3) begin
          if (mrdv[d] && rd_ready) begin mrdv[d] = 0; void'(mq[d].pop_front()); end
          else if (!mrdv[d] && mq[d].size() > 0) mrdv[d] = 1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_in();
    arm = 0; trigger = 0; ch_valid = '0; enable = 1; rd_ready = 0;
    ch_addr = '0; ch_data = '0;
  endtask

  task automatic event0(input logic [DW-1:0] a);
    ch_valid = 2'b01;
    ch_addr  = {$urandom, a};
    ch_data  = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    rst = 1; idle_in();
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (st[d] !== 3'd0 || cnt[d] !== '0 || drp[d] !== 16'd0 || rdv[d] !== 1'b0 || dn[d] !== 1'b0)
        $display("FAIL reset d%0d: st=%0d cnt=%0d drop=%0d rdv=%0d done=%0d, want all 0",
                 d, st[d], cnt[d], drp[d], rdv[d], dn[d]);
      else passed++;
    end
    rst = 0;
  endtask

  task automatic test_capture();
    int k;
    idle_in(); arm = 1; tick(); arm = 0;
    for (int i = 0; i < 3; i++) begin event0(32'h10 + 32'(4*i)); tick(); end
    ch_valid = '0; trigger = 1; tick(); trigger = 0;
    for (int i = 3; i < 5; i++) begin event0(32'h10 + 32'(4*i)); tick(); end
    ch_valid = '0;
    total++;
    if (st[0] !== 3'd3 || cnt[0] !== 7'd5 || dn[0] !== 1'b1 || st[1] !== 3'd3 || cnt[1] !== 7'd3)
      $display("FAIL capture_done: pt2 st=%0d cnt=%0d done=%0d pt0 st=%0d cnt=%0d, want 3/5/1 3/3",
               st[0], cnt[0], dn[0], st[1], cnt[1]);
    else passed++;
    rd_ready = 1; k = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rdv[0]) begin
        total++;
        if (raddr[0] !== 32'h10 + 32'(4*k))
          $display("FAIL capture_order word%0d: addr=%h want %h", k, raddr[0], 32'h10 + 32'(4*k));
        else passed++;
        k++;
      end
      for (int d = 0; d < 2; d++) begin
        total++;
        if (rdv[d] !== mrdv[d] || (mrdv[d] && (raddr[d] !== mq[d][0].a || rdata[d] !== mq[d][0].d)))
          $display("FAIL capture_read d%0d: rdv=%0d addr=%h data=%h want rdv=%0d", d, rdv[d], raddr[d], rdata[d], mrdv[d]);
        else passed++;
      end
    end
    total++;
    if (k !== 5 || cnt[0] !== '0 || st[0] !== 3'd3)
      $display("FAIL capture_drain: words=%0d cnt=%0d st=%0d, want 5 0 3", k, cnt[0], st[0]);
    else passed++;
  endtask

  task automatic test_wrap();
    logic [DW-1:0] first[2], last[2];
    int  nw[2];
    bit  prev[2];
    idle_in(); arm = 1; tick(); arm = 0;
    for (int i = 1; i <= 70; i++) begin event0(32'(i)); tick(); end
    ch_valid = '0; trigger = 1; tick(); trigger = 0;
    for (int i = 71; i <= 72; i++) begin event0(32'(i)); tick(); end
    ch_valid = '0;
    total++;
    if (cnt[0] !== 7'd64 || cnt[1] !== 7'd64 || st[0] !== 3'd3 || st[1] !== 3'd3)
      $display("FAIL wrap_count: cnt=%0d/%0d st=%0d/%0d, want 64/64 3/3", cnt[0], cnt[1], st[0], st[1]);
    else passed++;
    for (int d = 0; d < 2; d++) begin nw[d] = 0; prev[d] = rdv[d]; first[d] = '0; last[d] = '0; end
    // a word already valid before the loop is counted here
    for (int d = 0; d < 2; d++) if (rdv[d]) begin first[d] = raddr[d]; last[d] = raddr[d]; nw[d] = 1; end
    for (int c = 0; c < 600; c++) begin
      rd_ready = ($urandom_range(0, 3) != 0);
      tick();
      for (int d = 0; d < 2; d++) begin
        if (rdv[d] && !prev[d]) begin
          if (nw[d] == 0) first[d] = raddr[d];
          last[d] = raddr[d]; nw[d]++;
        end
        prev[d] = rdv[d];
        total++;
        if (rdv[d] !== mrdv[d] || cnt[d] !== 7'(mq[d].size()) || (mrdv[d] && raddr[d] !== mq[d][0].a))
          $display("FAIL wrap_read d%0d: rdv=%0d cnt=%0d addr=%h want rdv=%0d cnt=%0d", d, rdv[d], cnt[d], raddr[d], mrdv[d], mq[d].size());
        else passed++;
      end
    end
    rd_ready = 0;
    total++;
    if (nw[1] !== 64 || first[1] !== 32'd7 || last[1] !== 32'd70)
      $display("FAIL wrap_pt0: words=%0d first=%0d last=%0d, want 64 7 70", nw[1], first[1], last[1]);
    else passed++;
    total++;
    if (nw[0] !== 64 || first[0] !== 32'd9 || last[0] !== 32'd72)
      $display("FAIL wrap_pt2: words=%0d first=%0d last=%0d, want 64 9 72", nw[0], first[0], last[0]);
    else passed++;
  endtask

  task automatic test_drop();
    int k;
    idle_in(); arm = 1; tick(); arm = 0;
    for (int i = 0; i < 5; i++) begin
      ch_valid = 2'b11; ch_addr = {$urandom, $urandom}; ch_data = {$urandom, $urandom}; tick();
    end
    ch_valid = '0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (drp[d] !== 16'd5 || cnt[d] !== 7'd5)
        $display("FAIL drop5 d%0d: dropped=%0d cnt=%0d, want 5 5", d, drp[d], cnt[d]);
      else passed++;
    end
    trigger = 1; tick(); trigger = 0; rd_ready = 1; k = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (rdv[1]) begin
        total++;
        if (rch[1] !== 1'b0 || raddr[1] !== mq[1][0].a)
          $display("FAIL drop_ch word%0d: ch=%0d addr=%h want ch=0 addr=%h", k, rch[1], raddr[1], mq[1][0].a);
        else passed++;
        k++;
      end
    end
    rd_ready = 0;
    total++;
    if (k !== 5) $display("FAIL drop_words: got %0d want 5", k); else passed++;
    arm = 1; tick(); arm = 0;
    ch_valid = 2'b11;
    for (int i = 0; i < 65535; i++) tick();
    total++;
    if (drp[0] !== 16'hFFFF || drp[1] !== 16'hFFFF)
      $display("FAIL drop_65535: dropped=%h/%h want ffff", drp[0], drp[1]);
    else passed++;
    tick();
    ch_valid = '0;
    total++;
    if (drp[0] !== 16'hFFFF || drp[1] !== 16'hFFFF || cnt[0] !== 7'd64)
      $display("FAIL drop_sat: dropped=%h/%h cnt=%0d want ffff ffff 64", drp[0], drp[1], cnt[0]);
    else passed++;
  endtask

  task automatic test_stall();
    logic [DW-1:0] ha, hd;
    logic [0:0]    hc;
    int k;
    idle_in(); arm = 1; tick(); arm = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin ch_valid = '0; trigger = 1; tick(); trigger = 0; end
      ch_valid = 2'($urandom_range(1, 3)); ch_addr = {$urandom, $urandom}; ch_data = {$urandom, $urandom};
      tick();
    end
    ch_valid = '0; k = 0;
    while (!rdv[0] && k < 5) begin tick(); k++; end
    total++;
    if (rdv[0] !== 1'b1 || raddr[0] !== mq[0][0].a || rdata[0] !== mq[0][0].d || rch[0] !== 1'(mq[0][0].ch))
      $display("FAIL stall_first: rdv=%0d addr=%h data=%h want 1 %h %h", rdv[0], raddr[0], rdata[0], mq[0][0].a, mq[0][0].d);
    else passed++;
    ha = raddr[0]; hd = rdata[0]; hc = rch[0];
    for (int c = 0; c < 10; c++) begin
      tick();
      total++;
      if (rdv[0] !== 1'b1 || raddr[0] !== ha || rdata[0] !== hd || rch[0] !== hc)
        $display("FAIL stall_hold cyc%0d: rdv=%0d addr=%h data=%h want 1 %h %h", c, rdv[0], raddr[0], rdata[0], ha, hd);
      else passed++;
    end
    rd_ready = 1; tick(); rd_ready = 0;
    total++;
    if (rdv[0] !== 1'b0 || cnt[0] !== 7'd4)
      $display("FAIL stall_gap: rdv=%0d cnt=%0d want 0 4", rdv[0], cnt[0]);
    else passed++;
    tick();
    total++;
    if (rdv[0] !== 1'b1 || raddr[0] !== mq[0][0].a || rdata[0] !== mq[0][0].d)
      $display("FAIL stall_next: rdv=%0d addr=%h want 1 %h", rdv[0], raddr[0], mq[0][0].a);
    else passed++;
    arm = 1; tick(); arm = 0;
    total++;
    if (rdv[0] !== 1'b0 || rdv[1] !== 1'b0 || st[0] !== 3'd1 || st[1] !== 3'd1 || cnt[0] !== '0)
      $display("FAIL abort: rdv=%0d/%0d st=%0d/%0d cnt=%0d want 0/0 1/1 0", rdv[0], rdv[1], st[0], st[1], cnt[0]);
    else passed++;
  endtask

  task automatic test_rst_post();
    idle_in(); arm = 1; tick(); arm = 0;
    event0(32'h100); tick(); event0(32'h104); tick();
    ch_valid = '0; trigger = 1; tick(); trigger = 0;
    event0(32'h108); tick(); ch_valid = '0;
    total++;
    if (st[0] !== 3'd2 || cnt[0] !== 7'd3)
      $display("FAIL post_entry: st=%0d cnt=%0d want 2 3", st[0], cnt[0]);
    else passed++;
    rst = 1; tick(); rst = 0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (st[d] !== 3'd0 || cnt[d] !== '0 || dn[d] !== 1'b0)
        $display("FAIL rst_post d%0d: st=%0d cnt=%0d done=%0d want 0 0 0", d, st[d], cnt[d], dn[d]);
      else passed++;
    end
    trigger = 1;
    for (int i = 0; i < 3; i++) begin event0(32'h200); tick(); end
    trigger = 0; ch_valid = '0;
    total++;
    if (st[0] !== 3'd0 || st[1] !== 3'd0 || cnt[0] !== '0 || cnt[1] !== '0)
      $display("FAIL idle_trigger: st=%0d/%0d cnt=%0d/%0d want 0", st[0], st[1], cnt[0], cnt[1]);
    else passed++;
    arm = 1; tick(); arm = 0;
    total++;
    if (st[0] !== 3'd1 || st[1] !== 3'd1)
      $display("FAIL rearm: st=%0d/%0d want 1/1", st[0], st[1]);
    else passed++;
  endtask

  task automatic test_enable();
    idle_in(); arm = 1; tick(); arm = 0;
    enable = 0;
    for (int i = 0; i < 5; i++) begin
      ch_valid = 2'b11; ch_addr = {$urandom, $urandom}; ch_data = {$urandom, $urandom}; tick();
    end
    for (int d = 0; d < 2; d++) begin
      total++;
      if (cnt[d] !== '0 || drp[d] !== 16'd0)
        $display("FAIL enable_off d%0d: cnt=%0d dropped=%0d want 0 0", d, cnt[d], drp[d]);
      else passed++;
    end
    trigger = 1; tick(); trigger = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (st[1] !== 3'd3 || dn[1] !== 1'b1 || rdv[1] !== 1'b0 || st[0] !== 3'd2)
        $display("FAIL enable_trig: pt0 st=%0d done=%0d rdv=%0d pt2 st=%0d want 3 1 0 2", st[1], dn[1], rdv[1], st[0]);
      else passed++;
    end
    idle_in();
  endtask

  task automatic test_random();
    idle_in(); arm = 1; tick(); arm = 0;
    for (int c = 0; c < 1500; c++) begin
      rst      = ($urandom_range(0, 299) == 0);
      arm      = ($urandom_range(0, 59) == 0);
      trigger  = ($urandom_range(0, 9) == 0);
      enable   = ($urandom_range(0, 3) != 0);
      ch_valid = 2'($urandom_range(0, 3));
      ch_addr  = {$urandom, $urandom};
      ch_data  = {$urandom, $urandom};
      rd_ready = ($urandom_range(0, 2) != 0);
      tick();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (st[d] !== 3'(mst[d]) || cnt[d] !== 7'(mq[d].size()) || drp[d] !== 16'(mdrop[d]) ||
            rdv[d] !== mrdv[d] || dn[d] !== (mst[d] == 3) ||
            (mrdv[d] && (raddr[d] !== mq[d][0].a || rdata[d] !== mq[d][0].d || rch[d] !== 1'(mq[d][0].ch))))
          $display("FAIL rand d%0d cyc%0d: st=%0d cnt=%0d drop=%0d rdv=%0d addr=%h want st=%0d cnt=%0d drop=%0d rdv=%0d",
                   d, c, st[d], cnt[d], drp[d], rdv[d], raddr[d], mst[d], mq[d].size(), mdrop[d], mrdv[d]);
        else passed++;
      end
    end
    idle_in(); rst = 0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin mst[d] = 0; mpost[d] = 0; mdrop[d] = 0; mrdv[d] = 0; end
    test_reset();
    test_capture();
    test_wrap();
    test_drop();
    test_stall();
    test_rst_post();
    test_enable();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
